// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_t      arbiter FSM state (IDLE / BURST)
//   DEF_*            default parameter values
//   clog2_min1()     $clog2 clamped to a minimum of 1 bit, used to size index and counter fields
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  // A field that must hold values 0..n-1 still needs one bit when n <= 2.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req         request vector
//   last_owner  index of the most recent owner
//   next_owner  first set req bit scanning upward from last_owner+1, modulo N_REQ
//   any_req     at least one req bit is set
// When nothing is requested, next_owner is 0 and should be ignored.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int OW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    last_owner,
  output logic [OW-1:0]    next_owner,
  output logic             any_req
);

  // Scan from the farthest candidate down to the nearest one. The nearest set
  // bit after last_owner is written last and so wins, with no early exit.
  // The k == N_REQ candidate is last_owner itself, which has lowest priority.
  always_comb begin
    int idx;
    next_owner = '0;
    any_req    = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % N_REQ;
      if (req[idx]) next_owner = OW'(idx);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ requesters. Each grant covers a burst of up to MAX_BURST accepted
// writes. FIFO backpressure stalls the burst.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req          per-requester write request, held while data is valid
//   req_data     packed data; requester i at [i*DW +: DW]
//   gnt          one-hot grant, combinational, 0 while stalled or in reset
//   owner        current or last owner index
//   busy         high while in BURST
//   fifo_wr_en   FIFO write enable, which is the accept condition
//   fifo_din     FIFO write data, which is the owner's data in BURST, else 0
//   fifo_full    FIFO full flag
//   stall_cnt    saturating count of full-stall cycles; present only when
//                FIFO_WR_ARBITER_STATS_EN is defined
//
// The FIFO registers the write itself. An accept therefore happens in the
// same cycle as the grant. The IDLE cycle used for arbitration is the only
// cycle lost between bursts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int DW        = DEF_DW,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int OW        = clog2_min1(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [OW-1:0]       owner,
  output logic                busy,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_din,
  input  logic                fifo_full
`ifdef FIFO_WR_ARBITER_STATS_EN
  , output logic [15:0]       stall_cnt
`endif
);

  localparam int             BW        = clog2_min1(MAX_BURST + 1);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(MAX_BURST - 1);

  arb_state_t                 state, state_nxt;
  logic [OW-1:0]              owner_nxt, last_owner, last_nxt, pick;
  logic [BW-1:0]              beat_cnt, beat_nxt;
  logic                       any_req, own_req, live, accept;
  logic [N_REQ-1:0][DW-1:0]   data_arr;

  assign data_arr = req_data;
  assign own_req  = req[owner];
  // Reset overrides everything that would cause a write this cycle.
  assign live     = (state == BURST) && !rst;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .next_owner (pick),
    .any_req    (any_req)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(N_REQ - 1);   // requester 0 wins the first arbitration
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    beat_nxt  = beat_cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = pick;
          beat_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (!own_req) begin
          // The owner gives up the bus by dropping req. No write happens.
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (accept) begin
          if (beat_cnt == BEAT_LAST) begin
            last_nxt  = owner;
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            beat_nxt  = beat_cnt + BW'(1);
          end
        end
        // Otherwise the FIFO is full. Hold everything; no beat is counted.
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  for (genvar i = 0; i < N_REQ; i++) begin : g_gnt
    assign gnt[i] = live && (owner == OW'(i)) && !fifo_full;
  end

  always_comb begin
    accept   = live && !fifo_full && own_req;
    fifo_din = live ? data_arr[owner] : '0;
  end

  assign fifo_wr_en = accept;
  assign busy       = (state == BURST);

`ifdef FIFO_WR_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((state == BURST) && own_req && fifo_full && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [1:0]      owner;
  logic            busy, fifo_wr_en, fifo_full;
  logic [DW-1:0]   fifo_din;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0]     stall_cnt;
`endif

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .owner      (owner),
    .busy       (busy),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full)
`ifdef FIFO_WR_ARBITER_STATS_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       wr;
    logic [1:0] own;
    logic       busy;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   b1_writes = 0;
  logic sb_en = 1'b0;

  function automatic void add(int n, logic r, logic [3:0] rq, logic f,
                              logic [3:0] g, logic w, logic [1:0] o, logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.gnt = g; v.wr = w; v.own = o; v.busy = b;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  function automatic logic [7:0] data_of(logic [1:0] o);
    logic [N*DW-1:0] d;
    d = req_data;
    return d[o*DW +: DW];
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, k, act, exp);
    end
  endtask

  // Scoreboard for properties that must hold on every cycle
  always @(negedge clk) begin
    if (sb_en) begin
      total++;
      if (fifo_wr_en && fifo_full) begin
        bad++;
        $display("FAIL write_while_full t=%0t got=1 want=0", $time);
      end
      total++;
      if (!$onehot0(gnt)) begin
        bad++;
        $display("FAIL gnt_onehot t=%0t got=%b want=onehot0", $time, gnt);
      end
      if (fifo_wr_en && fifo_din == 8'hB1) b1_writes++;
    end
  end

  initial begin
    int m3, m4s, m4e, b1_snap, lat;
    logic [1:0] o_seen;
    logic [7:0] d_seen;

    rst = 1'b1; req = '0; fifo_full = 1'b0;
    req_data = 32'hD3C2B1A0;

    // Reset state, with state already reset
    add(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Single requester 0: bubble, 4 writes, bubble, 2 writes, release
    add(1, 0, 4'b0001, 0, 4'b0000, 0, 0, 0);
    add(4, 0, 4'b0001, 0, 4'b0001, 1, 0, 1);
    add(1, 0, 4'b0001, 0, 4'b0000, 0, 0, 0);
    add(2, 0, 4'b0001, 0, 4'b0001, 1, 0, 1);
    add(1, 0, 4'b0000, 0, 4'b0001, 0, 0, 1);
    add(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // All requesting after reset: owners 0,1,2,3,0, with 4 writes each
    add(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b1111, 0, 4'b0000, 0, 0, 0);
    for (int o = 0; o < 4; o++) begin
      add(4, 0, 4'b1111, 0, 4'(1 << o), 1, 2'(o), 1);
      add(1, 0, 4'b1111, 0, 4'b0000,    0, 2'(o), 0);
    end
    add(4, 0, 4'b1111, 0, 4'b0001, 1, 0, 1);
    add(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Requester 2 with a 3-cycle full stall mid-burst
    add(1, 0, 4'b0100, 0, 4'b0000, 0, 0, 0);
    add(2, 0, 4'b0100, 0, 4'b0100, 1, 2, 1);
    add(3, 0, 4'b0100, 1, 4'b0000, 0, 2, 1);
    add(2, 0, 4'b0100, 0, 4'b0100, 1, 2, 1);
    m3 = vq.size();
    add(1, 0, 4'b0000, 0, 4'b0000, 0, 2, 0);
    // Requester 1 releases after 2 beats, then requester 2 takes over
    m4s = vq.size();
    add(1, 0, 4'b0110, 0, 4'b0000, 0, 2, 0);
    add(2, 0, 4'b0110, 0, 4'b0010, 1, 1, 1);
    add(1, 0, 4'b0100, 0, 4'b0010, 0, 1, 1);
    add(1, 0, 4'b0100, 0, 4'b0000, 0, 1, 0);
    add(2, 0, 4'b0100, 0, 4'b0100, 1, 2, 1);
    m4e = vq.size();
    // Reset mid-burst: no write that cycle, then requester 0 wins first
    add(1, 1, 4'b0100, 0, 4'b0000, 0, 2, 1);
    add(1, 0, 4'b0101, 0, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0101, 0, 4'b0001, 1, 0, 1);
    add(1, 0, 4'b0000, 0, 4'b0001, 0, 0, 1);
    add(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    sb_en = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      if (k == m3) begin
`ifdef FIFO_WR_ARBITER_STATS_EN
        chk("stall_cnt_after_stall", k, 32'(stall_cnt), 32'd3);
`endif
      end
      if (k == m4s) b1_snap = b1_writes;
      if (k == m4e) chk("req1_write_count", k, 32'(b1_writes - b1_snap), 32'd2);
      rst       = vq[k].rst;
      req       = vq[k].req;
      fifo_full = vq[k].full;
      @(negedge clk);
      chk("gnt",   k, 32'(gnt),        32'(vq[k].gnt));
      chk("wr_en", k, 32'(fifo_wr_en), 32'(vq[k].wr));
      chk("owner", k, 32'(owner),      32'(vq[k].own));
      chk("busy",  k, 32'(busy),       32'(vq[k].busy));
      chk("din",   k, 32'(fifo_din),
          (vq[k].busy && !vq[k].rst) ? 32'(data_of(vq[k].own)) : 32'd0);
      @(posedge clk);
      #1;
    end

    // Lone requester 3 after the table: first write one cycle later, bounded wait
    rst = 1'b0; fifo_full = 1'b0; req = 4'b1000;
    lat = -1; o_seen = '0; d_seen = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fifo_wr_en && lat < 0) begin
        lat = c; o_seen = owner; d_seen = fifo_din;
      end
      @(posedge clk);
      #1;
    end
    chk("lone_req3_latency", 0, 32'(lat),    32'd1);
    chk("lone_req3_owner",   0, 32'(o_seen), 32'd3);
    chk("lone_req3_din",     0, 32'(d_seen), 32'hD3);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
`ifdef FIFO_WR_ARBITER_STATS_EN
    chk("stall_cnt_final", 0, 32'(stall_cnt), 32'd0);
`endif

    sb_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
